// File: rtl/key_conditioner.sv
// N-channel push-button front end: synchroniser, polarity normalisation, debouncer,
// registered press/release pulses and per-channel auto-repeat strobe.
`timescale 1ns / 1ps

module key_conditioner #(
  parameter int unsigned N               = 4,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [N-1:0] i_keys_in,
  input  logic [N-1:0] i_repeat_en,
  output logic [N-1:0] o_level,
  output logic [N-1:0] o_press,
  output logic [N-1:0] o_release,
  output logic [N-1:0] o_strobe
);

  localparam int unsigned DbW    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                  : REPEAT_PERIOD;
  localparam int unsigned RepW   = (RepMax > 1) ? $clog2(RepMax) : 1;

  localparam logic [DbW-1:0]  DbLast     = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RepW-1:0] DelayLast  = RepW'(REPEAT_DELAY - 1);
  localparam logic [RepW-1:0] PeriodLast = RepW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    StIdle,
    StHold,
    StRepeat
  } state_e;

  for (genvar g = 0; g < N; g++) begin : g_chan
    logic            r_sync1;
    logic            r_sync2;
    logic            w_s;
    logic [DbW-1:0]  r_db_cnt;
    logic [DbW-1:0]  w_db_cnt_next;
    logic            r_level;
    logic            w_level_next;
    logic            w_rise;
    logic            w_fall;
    state_e          r_state;
    state_e          w_state_next;
    logic [RepW-1:0] r_rep_cnt;
    logic [RepW-1:0] w_rep_cnt_next;
    logic            w_strobe_next;
    logic            r_press;
    logic            r_release;
    logic            r_strobe;

    // Flops reset to the idle pin value so reset release never looks like a press.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_sync1 <= ACTIVE_LOW;
        r_sync2 <= ACTIVE_LOW;
      end else begin
        r_sync1 <= i_keys_in[g];
        r_sync2 <= r_sync1;
      end
    end

    assign w_s = r_sync2 ^ ACTIVE_LOW;

    // Any cycle agreeing with the current level restarts the stability count.
    always_comb begin
      w_db_cnt_next = '0;
      w_level_next  = r_level;
      if (w_s != r_level) begin
        if (r_db_cnt == DbLast) begin
          w_level_next = w_s;
        end else begin
          w_db_cnt_next = r_db_cnt + DbW'(1);
        end
      end
    end

    assign w_rise = w_level_next & ~r_level;
    assign w_fall = ~w_level_next & r_level;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_db_cnt <= '0;
        r_level  <= 1'b0;
      end else begin
        r_db_cnt <= w_db_cnt_next;
        r_level  <= w_level_next;
      end
    end

    // Release outranks everything, including a coinciding repeat terminal count.
    always_comb begin
      w_state_next   = r_state;
      w_rep_cnt_next = r_rep_cnt;
      w_strobe_next  = 1'b0;
      if (w_fall) begin
        w_state_next   = StIdle;
        w_rep_cnt_next = '0;
      end else if (w_rise) begin
        w_state_next   = StHold;
        w_rep_cnt_next = '0;
        w_strobe_next  = 1'b1;
      end else begin
        case (r_state)
          StIdle: begin
            w_rep_cnt_next = '0;
          end
          StHold: begin
            if (!i_repeat_en[g]) begin
              w_rep_cnt_next = '0;
            end else if (r_rep_cnt == DelayLast) begin
              w_strobe_next  = 1'b1;
              w_rep_cnt_next = '0;
              w_state_next   = StRepeat;
            end else begin
              w_rep_cnt_next = r_rep_cnt + RepW'(1);
            end
          end
          StRepeat: begin
            if (!i_repeat_en[g]) begin
              w_rep_cnt_next = '0;
              w_state_next   = StHold;
            end else if (r_rep_cnt == PeriodLast) begin
              w_strobe_next  = 1'b1;
              w_rep_cnt_next = '0;
            end else begin
              w_rep_cnt_next = r_rep_cnt + RepW'(1);
            end
          end
          default: begin
            w_state_next   = StIdle;
            w_rep_cnt_next = '0;
          end
        endcase
      end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_state   <= StIdle;
        r_rep_cnt <= '0;
      end else begin
        r_state   <= w_state_next;
        r_rep_cnt <= w_rep_cnt_next;
      end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_press   <= 1'b0;
        r_release <= 1'b0;
        r_strobe  <= 1'b0;
      end else begin
        r_press   <= w_rise;
        r_release <= w_fall;
        r_strobe  <= w_strobe_next;
      end
    end

    assign o_level[g]   = r_level;
    assign o_press[g]   = r_press;
    assign o_release[g] = r_release;
    assign o_strobe[g]  = r_strobe;
  end

endmodule

// File: doc/key_conditioner.md
Name: key_conditioner

Overview:
Parametrised N-channel push-button front end that replaces direct use of raw KEY/SW pins in game logic. Per channel it provides:
- a two-flop synchroniser
- polarity normalisation
- a counter-based debouncer
- registered press/release pulses
- an optional per-channel auto-repeat strobe for paddle movement

It sits between the board top level (KEY[3:0], SW) and GameLogic, clocked from CLOCK2_50.

Parameters:
N, 4, number of independent channels
ACTIVE_LOW, 1, 1 = pin reads 0 when pressed (DE2-115 KEY); 0 = active-high (SW)
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles before level changes (20 ms @ 50 MHz); minimum 1
REPEAT_DELAY, 25000000, cycles from press pulse to first repeat strobe; minimum 1
REPEAT_PERIOD, 5000000, cycles between subsequent repeat strobes; minimum 1

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
keys_in  in  N  raw pin inputs, asynchronous
repeat_en  in  N  per-channel auto-repeat enable, synchronous to clk
level  out  N  debounced state, 1 = pressed
press  out  N  one-cycle pulse on debounced 0->1
release  out  N  one-cycle pulse on debounced 1->0
strobe  out  N  one-cycle pulse on press and on each auto-repeat event

Behaviour:
- Reset, rst_n low, asynchronous, per channel:
  - synchroniser flops = ACTIVE_LOW (idle pin value)
  - debounce counter = 0, repeat counter = 0, FSM = IDLE
  - level/press/release/strobe = 0
  - Reset mid-operation discards everything in flight. No pulse is emitted on the release of reset.
- Synchroniser: two flops per channel. s = sync2 XOR ACTIVE_LOW (1 = pressed).
- Debounce counter:
  - Width ceil(log2(DEBOUNCE_CYCLES)), minimum 1.
  - Each edge with s == level: counter <= 0.
  - Each edge with s != level: if counter == DEBOUNCE_CYCLES-1, then level <= s and counter <= 0; else counter++.
  - Any single-cycle agreement restarts the count (glitch rejection).
  - Latency from a stable pin change to level update: 2 + DEBOUNCE_CYCLES edges.
- press/release: asserted on the same edge level changes; high exactly one cycle. Both are never high together on a channel.
- Repeat FSM per channel: states IDLE, HOLD, REPEAT. Repeat counter width is sized for max(REPEAT_DELAY, REPEAT_PERIOD).
  - IDLE: on level rising edge -> HOLD, r <= 0, strobe = 1 (coincident with press).
  - HOLD:
    - If repeat_en = 0: r <= 0, stay in HOLD.
    - Else if r == REPEAT_DELAY-1: strobe = 1, r <= 0, -> REPEAT.
    - Else r++.
  - REPEAT:
    - If repeat_en = 0: r <= 0, -> HOLD. The full delay applies again after re-enable.
    - Else if r == REPEAT_PERIOD-1: strobe = 1, r <= 0.
    - Else r++.
  - Any state, on level falling edge (release): -> IDLE, r <= 0, no strobe that cycle. Release takes priority over a coinciding repeat terminal count.
- Timing of strobes: the first repeat strobe occurs REPEAT_DELAY cycles after the press strobe. Subsequent strobes occur every REPEAT_PERIOD cycles.
- Channels are fully independent. Simultaneous events on different channels produce independent pulses in the same cycle.
- All outputs are registered; no combinational path from keys_in or repeat_en to outputs.

Test Plan:
Unless a case states otherwise, use N=2, ACTIVE_LOW=1, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
- Reset: rst_n low with keys_in=2'b00 (both pressed) -> all outputs 0. After rst_n rises, level[1:0]=2'b11 at edge 6, with press=strobe=2'b11 for exactly that one cycle.
- Glitch: keys_in[0] low for 3 cycles then high -> level[0], press[0], strobe[0] stay 0. Low for 4+ cycles -> level[0]=1 on edge 6 after the pin change.
- Auto-repeat: repeat_en[0]=1, hold key 30 cycles after press pulse at cycle T -> strobes at T, T+10, T+13, T+16, ..., T+28. Releasing the key -> release pulse 6 edges after the pin rises, no further strobes.
- repeat_en cleared in REPEAT at T+14 and set at T+20 -> no strobe until T+30.
- Release coinciding with repeat terminal count -> release=1, strobe=0 that cycle, FSM IDLE.
- ACTIVE_LOW=0, DEBOUNCE_CYCLES=1: pin 0->1 -> level=1 at edge 3. Asserting rst_n mid-HOLD -> outputs 0 immediately without waiting for a clock edge.
